axi_lite_slave_waitstate: RTL and testbench
===========================================

Name: axi_lite_slave_waitstate

Overview:
AXI4-Lite slave protocol controller that adds address-window decode and a wait-state-capable user bus to the basic slave.
- Buffers one write address and one write data beat independently, in either order, and handles reads in parallel.
- Issues single-cycle user requests and holds the AXI response until the user side acknowledges.
- Sits between the system interconnect and peripheral register banks that may need multiple cycles per access.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width; must be 32 or 64
BASE_ADDR, 32'h0000_0000, first byte address of the decoded window
ADDR_SPAN, 4096, window size in bytes; must be a power of two
OFFS_WIDTH, 12, user offset width; must equal log2(ADDR_SPAN)
TIMEOUT_CYCLES, 256, user-ack timeout in cycles; only used when AXIL_TIMEOUT_EN is defined

Ports:
aclk  in  1  clock; all logic is rising-edge
aresetn  in  1  asynchronous active-low reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read valid
rready  in  1  read ready
user_wr_en  out  1  one-cycle write request
user_wr_addr  out  OFFS_WIDTH  byte offset, computed as awaddr-BASE_ADDR
user_wr_data  out  DATA_WIDTH  write data
user_wr_strb  out  DATA_WIDTH/8  byte strobes
user_wr_ack  in  1  write complete; allowed in the same cycle as user_wr_en
user_wr_resp  in  2  write response, sampled with user_wr_ack
user_rd_en  out  1  one-cycle read request
user_rd_addr  out  OFFS_WIDTH  byte offset
user_rd_valid  in  1  read data valid; allowed in the same cycle as user_rd_en
user_rd_data  in  DATA_WIDTH  read data, sampled with user_rd_valid
user_rd_resp  in  2  read response, sampled with user_rd_valid

Behaviour:
- Reset:
  - Every output and internal flag resets to 0.
  - awready, wready and arready rise on the first aclk edge after aresetn deasserts.
  - Reset asserted mid-transaction abandons it; no response is issued afterwards.
- All AXI outputs are registered; there are no combinational paths from any input to any AXI output.
- Write capture:
  - aw_full and w_full are one-entry holding flags.
  - awready = !aw_full and wready = !w_full; each drops the cycle after its handshake.
  - AW and W may arrive in the same cycle or in either order with any gap.
- Write FSM, states WR_IDLE, WR_WAIT, WR_RESP:
  - WR_IDLE with aw_full&&w_full and the address in the window: pulse user_wr_en for 1 cycle, go to WR_WAIT.
  - WR_IDLE with aw_full&&w_full and the address outside the window: no user access; bresp=2'b11 (DECERR); go to WR_RESP.
  - WR_WAIT on user_wr_ack: register user_wr_resp into bresp, set bvalid, go to WR_RESP.
  - WR_RESP: bvalid holds until bready. On the handshake clear bvalid, aw_full and w_full, and return to WR_IDLE; awready and wready reassert the next cycle.
- In-window check: BASE_ADDR <= addr < BASE_ADDR+ADDR_SPAN, using ADDR_WIDTH unsigned arithmetic. addr[1:0] is ignored for decode and passed through in the offset.
- Read FSM, states RD_IDLE, RD_WAIT, RD_RESP:
  - arready is 1 only in RD_IDLE and drops the cycle after the AR handshake.
  - On an in-window AR handshake: pulse user_rd_en, go to RD_WAIT.
  - On an out-of-window AR handshake: rdata=0, rresp=2'b11, go to RD_RESP.
  - RD_WAIT on user_rd_valid: register rdata and rresp, assert rvalid.
  - rdata, rresp and rvalid are stable until rready; then return to RD_IDLE.
- Read and write paths are fully independent; a simultaneous user_wr_en and user_rd_en is legal.
- Latency, with the final handshake at edge N and zero user wait:
  - user_wr_en or user_rd_en is high in cycle N+1.
  - bvalid or rvalid is high from cycle N+2.
- user_wr_ack or user_rd_valid arriving outside its WAIT state is ignored.

Optional Feature:
AXIL_TIMEOUT_EN
- Defined:
  - A counter clears on user_*_en and increments each cycle in WR_WAIT or RD_WAIT.
  - At count TIMEOUT_CYCLES-1 without an ack, the FSM moves to *_RESP with resp=2'b10 (SLVERR), and rdata=0 for reads.
  - One separate counter per path.
- Undefined: there is no counter, and the FSM waits indefinitely for the ack.

Test Plan:
1. AW 0x10 and W 0xDEADBEEF/strb 0xF in the same cycle, user_wr_ack with resp 00 in the cycle user_wr_en is high -> user_wr_addr=0x10, user_wr_data=0xDEADBEEF, bvalid two cycles after the handshake, bresp=00.
2. W first, AW 3 cycles later, bready held low 4 cycles -> a single user_wr_en pulse; bvalid is held, and awready/wready stay 0 until the B handshake.
3. AR 0x24, user_rd_valid 5 cycles after user_rd_en with data 0x12345678 and resp 00 -> rvalid=1, rdata=0x12345678, rresp=00; arready=0 during the wait.
4. Write and read to 0x2000 with BASE_ADDR=0 and ADDR_SPAN=4096 -> no user_*_en; bresp=11; rresp=11 with rdata=0.
5. With AXIL_TIMEOUT_EN and TIMEOUT_CYCLES=8, a read with no user_rd_valid -> rvalid 8 cycles after user_rd_en, rresp=10, rdata=0; a late user_rd_valid is ignored.
6. aresetn pulsed low during WR_WAIT -> all outputs 0, no bvalid; the next write completes normally.

Source files
------------

// File: rtl/axi_lite_slave_waitstate_if.sv
// axi_lite_slave_waitstate_if: AXI4-Lite bus bundle between interconnect (master) and slave.
interface axi_lite_slave_waitstate_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_slave_waitstate.sv
// axi_lite_slave_waitstate: AXI4-Lite slave with address-window decode and a wait-state user bus.
// Define AXIL_TIMEOUT_EN to end user waits after TIMEOUT_CYCLES with SLVERR.
module axi_lite_slave_waitstate #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_SPAN      = 4096,
  parameter int                    OFFS_WIDTH     = 12,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi_lite_slave_waitstate_if.slave s,
  output logic                    user_wr_en,
  output logic [OFFS_WIDTH-1:0]   user_wr_addr,
  output logic [DATA_WIDTH-1:0]   user_wr_data,
  output logic [DATA_WIDTH/8-1:0] user_wr_strb,
  input  logic                    user_wr_ack,
  input  logic [1:0]              user_wr_resp,
  output logic                    user_rd_en,
  output logic [OFFS_WIDTH-1:0]   user_rd_addr,
  input  logic                    user_rd_valid,
  input  logic [DATA_WIDTH-1:0]   user_rd_data,
  input  logic [1:0]              user_rd_resp
);
  localparam int SW = DATA_WIDTH / 8;
  if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || (ADDR_SPAN & (ADDR_SPAN - 1)) != 0 ||
      OFFS_WIDTH != $clog2(ADDR_SPAN) || TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("axi_lite_slave_waitstate: invalid parameter set");
  end
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_e;
  // Low address bits never affect the decode; they only flow through in the offset.
  function automatic logic in_win(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] w;
    w = a & ~ADDR_WIDTH'(3);
    return (w >= BASE_ADDR) && ((w - BASE_ADDR) < ADDR_WIDTH'(ADDR_SPAN));
  endfunction
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  aw_in_q, aw_in_d;
  logic [OFFS_WIDTH-1:0] aw_off_q, aw_off_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  user_wr_en_q, user_wr_en_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  ar_full_q, ar_full_d, arready_q, arready_d;
  logic                  ar_in_q, ar_in_d;
  logic [OFFS_WIDTH-1:0] ar_off_q, ar_off_d;
  logic                  user_rd_en_q, user_rd_en_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
`ifdef AXIL_TIMEOUT_EN
  localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
`endif
  always_comb begin
    wr_state_d   = wr_state_q;
    aw_full_d    = aw_full_q;
    w_full_d     = w_full_q;
    aw_in_d      = aw_in_q;
    aw_off_d     = aw_off_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    user_wr_en_d = 1'b0;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
`ifdef AXIL_TIMEOUT_EN
    wr_cnt_d     = '0;
`endif
    if (s.awvalid && awready_q) begin
      aw_full_d = 1'b1;
      aw_in_d   = in_win(s.awaddr);
      aw_off_d  = OFFS_WIDTH'(s.awaddr - BASE_ADDR);
    end
    if (s.wvalid && wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = s.wdata;
      wstrb_d  = s.wstrb;
    end
    case (wr_state_q)
      WR_IDLE: if (aw_full_q && w_full_q) begin
        if (aw_in_q) begin
          user_wr_en_d = 1'b1;
          wr_state_d   = WR_WAIT;
        end else begin
          bresp_d    = 2'b11;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
      end
      WR_WAIT: begin
        if (user_wr_ack) begin
          bresp_d    = user_wr_resp;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
        end
`ifdef AXIL_TIMEOUT_EN
        else if (wr_cnt_q == CNT_MAX) begin
          bresp_d    = 2'b10;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
        end else wr_cnt_d = wr_cnt_q + 1'b1;
`endif
      end
      WR_RESP: if (s.bready) begin
        bvalid_d   = 1'b0;
        aw_full_d  = 1'b0;
        w_full_d   = 1'b0;
        wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
  end
  // A captured AR is issued one cycle later so read latency matches the write path.
  always_comb begin
    rd_state_d   = rd_state_q;
    ar_full_d    = ar_full_q;
    ar_in_d      = ar_in_q;
    ar_off_d     = ar_off_q;
    user_rd_en_d = 1'b0;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
`ifdef AXIL_TIMEOUT_EN
    rd_cnt_d     = '0;
`endif
    case (rd_state_q)
      RD_IDLE: if (ar_full_q) begin
        ar_full_d = 1'b0;
        if (ar_in_q) begin
          user_rd_en_d = 1'b1;
          rd_state_d   = RD_WAIT;
        end else begin
          rdata_d    = '0;
          rresp_d    = 2'b11;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end
      end else if (s.arvalid && arready_q) begin
        ar_full_d = 1'b1;
        ar_in_d   = in_win(s.araddr);
        ar_off_d  = OFFS_WIDTH'(s.araddr - BASE_ADDR);
      end
      RD_WAIT: begin
        if (user_rd_valid) begin
          rdata_d    = user_rd_data;
          rresp_d    = user_rd_resp;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end
`ifdef AXIL_TIMEOUT_EN
        else if (rd_cnt_q == CNT_MAX) begin
          rdata_d    = '0;
          rresp_d    = 2'b10;
          rvalid_d   = 1'b1;
          rd_state_d = RD_RESP;
        end else rd_cnt_d = rd_cnt_q + 1'b1;
`endif
      end
      RD_RESP: if (s.rready) begin
        rvalid_d   = 1'b0;
        rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE) && !ar_full_d;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q   <= WR_IDLE;
      aw_full_q    <= 1'b0;
      w_full_q     <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      aw_in_q      <= 1'b0;
      aw_off_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      user_wr_en_q <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rd_state_q   <= RD_IDLE;
      ar_full_q    <= 1'b0;
      arready_q    <= 1'b0;
      ar_in_q      <= 1'b0;
      ar_off_q     <= '0;
      user_rd_en_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
`ifdef AXIL_TIMEOUT_EN
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
`endif
    end else begin
      wr_state_q   <= wr_state_d;
      aw_full_q    <= aw_full_d;
      w_full_q     <= w_full_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      aw_in_q      <= aw_in_d;
      aw_off_q     <= aw_off_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      user_wr_en_q <= user_wr_en_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rd_state_q   <= rd_state_d;
      ar_full_q    <= ar_full_d;
      arready_q    <= arready_d;
      ar_in_q      <= ar_in_d;
      ar_off_q     <= ar_off_d;
      user_rd_en_q <= user_rd_en_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
`ifdef AXIL_TIMEOUT_EN
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
`endif
    end
  end
  assign s.awready    = awready_q;
  assign s.wready     = wready_q;
  assign s.bvalid     = bvalid_q;
  assign s.bresp      = bresp_q;
  assign s.arready    = arready_q;
  assign s.rvalid     = rvalid_q;
  assign s.rresp      = rresp_q;
  assign s.rdata      = rdata_q;
  assign user_wr_en   = user_wr_en_q;
  assign user_wr_addr = aw_off_q;
  assign user_wr_data = wdata_q;
  assign user_wr_strb = wstrb_q;
  assign user_rd_en   = user_rd_en_q;
  assign user_rd_addr = ar_off_q;
endmodule

// File: tb/tb_axi_lite_slave_waitstate.sv
// tb_axi_lite_slave_waitstate: directed stimulus with a queue scoreboard checked by a separate monitor.
`timescale 1ns/1ps
module tb_axi_lite_slave_waitstate;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;
  axi_lite_slave_waitstate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
  logic        user_wr_en, user_wr_ack, user_rd_en, user_rd_valid;
  logic [11:0] user_wr_addr, user_rd_addr;
  logic [31:0] user_wr_data, user_rd_data;
  logic [3:0]  user_wr_strb;
  logic [1:0]  user_wr_resp, user_rd_resp;
  axi_lite_slave_waitstate #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h0), .ADDR_SPAN(4096),
    .OFFS_WIDTH(12), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .s(bus),
    .user_wr_en(user_wr_en), .user_wr_addr(user_wr_addr), .user_wr_data(user_wr_data),
    .user_wr_strb(user_wr_strb), .user_wr_ack(user_wr_ack), .user_wr_resp(user_wr_resp),
    .user_rd_en(user_rd_en), .user_rd_addr(user_rd_addr), .user_rd_valid(user_rd_valid),
    .user_rd_data(user_rd_data), .user_rd_resp(user_rd_resp)
  );
  int total = 0;
  int bad = 0;
  int wr_delay = 0;
  int rd_delay = 0;
  logic [1:0]  wr_resp_val = 2'b00;
  logic [1:0]  rd_resp_val = 2'b00;
  logic [31:0] rd_data_val = 32'h0;
  int uw_cnt = 0;
  int ur_cnt = 0;
  typedef struct packed {logic [11:0] a; logic [31:0] d; logic [3:0] s;} uw_t;
  uw_t         exp_uw[$];
  logic [11:0] exp_ur[$];
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask
  // Scoreboard monitor: every user request and every AXI response handshake pops one entry.
  initial begin : mon
    uw_t e;
    logic [33:0] r;
    forever begin
      @(negedge aclk);
      if (user_wr_en) begin
        uw_cnt++;
        if (exp_uw.size() == 0) timeout("uw_unexpected");
        else begin
          e = exp_uw.pop_front();
          chk("uw_addr", 64'(user_wr_addr), 64'(e.a));
          chk("uw_data", 64'(user_wr_data), 64'(e.d));
          chk("uw_strb", 64'(user_wr_strb), 64'(e.s));
        end
      end
      if (user_rd_en) begin
        ur_cnt++;
        if (exp_ur.size() == 0) timeout("ur_unexpected");
        else chk("ur_addr", 64'(user_rd_addr), 64'(exp_ur.pop_front()));
      end
      if (bus.bvalid && bus.bready) begin
        if (exp_b.size() == 0) timeout("b_unexpected");
        else chk("bresp", 64'(bus.bresp), 64'(exp_b.pop_front()));
      end
      if (bus.rvalid && bus.rready) begin
        if (exp_r.size() == 0) timeout("r_unexpected");
        else begin
          r = exp_r.pop_front();
          chk("rdata", 64'(bus.rdata), 64'(r[33:2]));
          chk("rresp", 64'(bus.rresp), 64'(r[1:0]));
        end
      end
    end
  end
  initial begin : wr_user
    int left;
    left = -1;
    user_wr_ack = 1'b0;
    user_wr_resp = 2'b00;
    forever begin
      @(negedge aclk);
      user_wr_ack = 1'b0;
      if (user_wr_en) left = wr_delay;
      if (left == 0) begin
        user_wr_ack = 1'b1;
        user_wr_resp = wr_resp_val;
      end
      if (left >= 0) left--;
    end
  end
  initial begin : rd_user
    int left;
    left = -1;
    user_rd_valid = 1'b0;
    user_rd_data = 32'h0;
    user_rd_resp = 2'b00;
    forever begin
      @(negedge aclk);
      user_rd_valid = 1'b0;
      if (user_rd_en) left = rd_delay;
      if (left == 0) begin
        user_rd_valid = 1'b1;
        user_rd_data = rd_data_val;
        user_rd_resp = rd_resp_val;
      end
      if (left >= 0) left--;
    end
  end
  task automatic send_aw(input logic [31:0] a, input int gap);
    repeat (gap) @(posedge aclk);
    #1 bus.awaddr = a;
    bus.awvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      if (n == 50) begin timeout("aw_handshake"); break; end
      @(negedge aclk);
      if (bus.awready) break;
    end
    @(posedge aclk);
    #1 bus.awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input int gap);
    repeat (gap) @(posedge aclk);
    #1 bus.wdata = d;
    bus.wstrb = st;
    bus.wvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      if (n == 50) begin timeout("w_handshake"); break; end
      @(negedge aclk);
      if (bus.wready) break;
    end
    @(posedge aclk);
    #1 bus.wvalid = 1'b0;
  endtask
  task automatic send_ar(input logic [31:0] a);
    #1 bus.araddr = a;
    bus.arvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      if (n == 50) begin timeout("ar_handshake"); break; end
      @(negedge aclk);
      if (bus.arready) break;
    end
    @(posedge aclk);
    #1 bus.arvalid = 1'b0;
  endtask
  // Counts rising edges until the selected signal is seen high (0 bvalid, 1 rvalid, 2 wr_en, 3 rd_en).
  task automatic edges_until(input int sel, output int k);
    logic v;
    k = 0;
    while (k < 100) begin
      @(posedge aclk);
      #1 k++;
      v = sel == 0 ? bus.bvalid : sel == 1 ? bus.rvalid : sel == 2 ? user_wr_en : user_rd_en;
      if (v) break;
    end
  endtask
  task automatic chk_all_zero(input string name);
    chk({name, "_axi"}, 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid,
                              bus.bresp, bus.rresp, bus.rdata}), 64'(0));
    chk({name, "_user"}, 64'({user_wr_en, user_rd_en, user_wr_addr, user_rd_addr, user_wr_strb}), 64'(0));
    chk({name, "_wdata"}, 64'(user_wr_data), 64'(0));
  endtask
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin : stim
    int k, c0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 chk_all_zero("reset");
    aresetn = 1'b1;
    chk("ready_before_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'(0));
    @(posedge aclk);
    #1 chk("ready_after_edge", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
    // 1: AW and W together, zero-wait ack
    exp_uw.push_back({12'h010, 32'hDEADBEEF, 4'hF});
    exp_b.push_back(2'b00);
    fork
      send_aw(32'h10, 0);
      send_w(32'hDEADBEEF, 4'hF, 0);
    join
    edges_until(2, k);
    chk("t1_wr_en_lat", 64'(k), 64'(1));
    edges_until(0, k);
    chk("t1_bvalid_lat", 64'(k), 64'(1));
    repeat (3) @(posedge aclk);
    // 2: W first, AW three cycles later, B held off
    bus.bready = 1'b0;
    wr_delay = 2;
    wr_resp_val = 2'b01;
    c0 = uw_cnt;
    exp_uw.push_back({12'h020, 32'hCAFEF00D, 4'b0101});
    exp_b.push_back(2'b01);
    send_w(32'hCAFEF00D, 4'b0101, 0);
    chk("t2_w_only", 64'({bus.wready, bus.awready}), 64'(2'b01));
    send_aw(32'h20, 2);
    edges_until(0, k);
    chk("t2_bvalid_seen", 64'(k < 100), 64'(1));
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk);
      #1 chk("t2_hold", 64'({bus.bvalid, bus.awready, bus.wready}), 64'(3'b100));
    end
    bus.bready = 1'b1;
    @(posedge aclk);
    #1 chk("t2_after_b", 64'({bus.bvalid, bus.awready, bus.wready}), 64'(3'b011));
    chk("t2_one_pulse", 64'(uw_cnt - c0), 64'(1));
    repeat (2) @(posedge aclk);
    // 3: read with a five-cycle user wait
    rd_delay = 5;
    rd_data_val = 32'h12345678;
    rd_resp_val = 2'b00;
    exp_ur.push_back(12'h024);
    exp_r.push_back({32'h12345678, 2'b00});
    send_ar(32'h24);
    chk("t3_arready_drop", 64'(bus.arready), 64'(0));
    edges_until(3, k);
    chk("t3_rd_en_lat", 64'(k), 64'(1));
    chk("t3_arready_wait", 64'(bus.arready), 64'(0));
    edges_until(1, k);
    chk("t3_rvalid_lat", 64'(k), 64'(6));
    chk("t3_arready_resp", 64'(bus.arready), 64'(0));
    repeat (3) @(posedge aclk);
    // 4: out-of-window write and read
    c0 = uw_cnt;
    exp_b.push_back(2'b11);
    fork
      send_aw(32'h2000, 0);
      send_w(32'h11111111, 4'hF, 0);
    join
    edges_until(0, k);
    chk("t4_b_seen", 64'(k < 100), 64'(1));
    repeat (2) @(posedge aclk);
    chk("t4_no_wr_en", 64'(uw_cnt - c0), 64'(0));
    c0 = ur_cnt;
    exp_r.push_back({32'h0, 2'b11});
    send_ar(32'h2000);
    edges_until(1, k);
    chk("t4_r_seen", 64'(k < 100), 64'(1));
    repeat (2) @(posedge aclk);
    chk("t4_no_rd_en", 64'(ur_cnt - c0), 64'(0));
`ifdef AXIL_TIMEOUT_EN
    // 5: read timeout, late user_rd_valid ignored
    bus.rready = 1'b0;
    rd_delay = 10;
    rd_data_val = 32'hBAD0BAD0;
    exp_ur.push_back(12'h030);
    exp_r.push_back({32'h0, 2'b10});
    send_ar(32'h30);
    edges_until(3, k);
    edges_until(1, k);
    chk("t5_timeout_lat", 64'(k), 64'(8));
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk);
      #1 chk("t5_hold", 64'({bus.rvalid, bus.rresp, bus.rdata}), 64'({1'b1, 2'b10, 32'h0}));
    end
    bus.rready = 1'b1;
    @(posedge aclk);
    #1 chk("t5_rvalid_clear", 64'(bus.rvalid), 64'(0));
    repeat (2) @(posedge aclk);
`endif
    // 6: reset during WR_WAIT abandons the write
    wr_delay = -1;
    wr_resp_val = 2'b00;
    exp_uw.push_back({12'h040, 32'h0BADF00D, 4'h3});
    fork
      send_aw(32'h40, 0);
      send_w(32'h0BADF00D, 4'h3, 0);
    join
    edges_until(2, k);
    chk("t6_wr_en_seen", 64'(k), 64'(1));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;
    #1 chk_all_zero("t6_reset");
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1 chk("t6_ready_back", 64'({bus.awready, bus.wready, bus.arready}), 64'(3'b111));
    repeat (4) @(posedge aclk);
    #1 chk("t6_no_bvalid", 64'(bus.bvalid), 64'(0));
    wr_delay = 0;
    exp_uw.push_back({12'h044, 32'h55AA55AA, 4'hF});
    exp_b.push_back(2'b00);
    fork
      send_aw(32'h44, 0);
      send_w(32'h55AA55AA, 4'hF, 0);
    join
    edges_until(2, k);
    chk("t6_wr_en_lat", 64'(k), 64'(1));
    edges_until(0, k);
    chk("t6_bvalid_lat", 64'(k), 64'(1));
    repeat (5) @(posedge aclk);
    chk("sb_drain", 64'(exp_uw.size() + exp_ur.size() + exp_b.size() + exp_r.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
